// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution engine.
package conv_pkg;

  localparam int DW_DEFAULT   = 16;
  localparam int FRAC_DEFAULT = 15;
  localparam int SAT_W        = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  // Full-precision sum of TAPS products of two DW-bit operands.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Floor-shift by frac, then clamp into the signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] shift_sat(
    input logic signed [SAT_W-1:0] acc,
    input int frac,
    input int dw
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> frac;
    max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) return max_v;
    if (shifted < min_v) return min_v;
    return shifted;
  endfunction

endpackage

// File: rtl/conv_tap_sum.sv
// Combinational multiply-accumulate of one output sample over a TAPS-wide window.
module conv_tap_sum
  import conv_pkg::*;
#(
  parameter int TAPS = 20,
  parameter int DW   = DW_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic [TAPS*DW-1:0] i_coeff,
  input  logic [TAPS*DW-1:0] i_window,
  output logic [DW-1:0]      o_y
);

  localparam int ACC_W = acc_width(DW, TAPS);

  logic signed [DW-1:0]    w_h    [TAPS];
  logic signed [DW-1:0]    w_x    [TAPS];
  logic signed [2*DW-1:0]  w_prod [TAPS];
  logic signed [ACC_W-1:0] w_acc;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_mul
      assign w_h[gi]    = i_coeff[gi*DW +: DW];
      assign w_x[gi]    = i_window[gi*DW +: DW];
      assign w_prod[gi] = (2*DW)'(w_h[gi]) * (2*DW)'(w_x[gi]);
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'(w_prod[k]);
    end
  end

  assign o_y = DW'(shift_sat(SAT_W'(w_acc), FRAC, DW));

endmodule

// File: rtl/convolve_engine.sv
// Direct-form linear convolution, one full-length output sample per clock.
module convolve_engine
  import conv_pkg::*;
#(
  parameter int TAPS    = 20,
  parameter int SIG_LEN = 2401,
  parameter int DW      = DW_DEFAULT,
  parameter int FRAC    = FRAC_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic [TAPS*DW-1:0]                filter_coeff,
  input  logic [SIG_LEN*DW-1:0]             signal_in,
  output logic [(SIG_LEN+TAPS-1)*DW-1:0]    conv_result,
  output logic                              is_completed
);

  localparam int OUT_LEN = SIG_LEN + TAPS - 1;
  localparam int NW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int SW      = (SIG_LEN > 1) ? $clog2(SIG_LEN) : 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [NW-1:0]     r_n;
  logic              r_done;
  logic [TAPS*DW-1:0] r_coeff;
  logic [DW-1:0]     r_sig [SIG_LEN];
  logic [DW-1:0]     r_res [OUT_LEN];
  logic [TAPS*DW-1:0] w_window;
  logic [DW-1:0]     w_y;
  logic              w_last;

  assign w_last = (r_n == NW'(OUT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (load) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:    w_state_next = ST_COMPUTE;
        ST_COMPUTE: if (w_last) w_state_next = ST_DONE;
        default:    w_state_next = r_state;
      endcase
    end
  end

  // Window tap k holds x[n-k]; the unsigned offset wraps negative, caught by its top bit.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_win
      logic [NW:0] w_off;
      assign w_off = {1'b0, r_n} - (NW+1)'(gi);
      assign w_window[gi*DW +: DW] =
        (!w_off[NW] && (w_off[NW-1:0] < NW'(SIG_LEN))) ? r_sig[w_off[SW-1:0]] : '0;
    end
  endgenerate

  conv_tap_sum #(
    .TAPS (TAPS),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_tap_sum (
    .i_coeff  (r_coeff),
    .i_window (w_window),
    .o_y      (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_done  <= 1'b0;
      r_coeff <= '0;
      for (int i = 0; i < SIG_LEN; i++) r_sig[i] <= '0;
      for (int i = 0; i < OUT_LEN; i++) r_res[i] <= '0;
    end else if (load) begin
      r_n     <= '0;
      r_done  <= 1'b0;
      r_coeff <= filter_coeff;
      for (int i = 0; i < SIG_LEN; i++) r_sig[i] <= signal_in[i*DW +: DW];
      for (int i = 0; i < OUT_LEN; i++) r_res[i] <= '0;
    end else if (r_state == ST_COMPUTE) begin
      r_res[r_n] <= w_y;
      if (w_last) r_done <= 1'b1;
      else        r_n    <= r_n + 1'b1;
    end
  end

  generate
    for (gi = 0; gi < OUT_LEN; gi++) begin : g_out
      assign conv_result[gi*DW +: DW] = r_res[gi];
    end
  endgenerate

  assign is_completed = r_done;

endmodule

// File: tb/tb_convolve_engine.sv
// Directed-vector bench for convolve_engine at default parameters.
module tb_convolve_engine;

  localparam int TAPS    = 20;
  localparam int SIG_LEN = 2401;
  localparam int DW      = 16;
  localparam int OUT_LEN = SIG_LEN + TAPS - 1;
  localparam int LAT     = OUT_LEN + 1;

  logic                     clk;
  logic                     rst_n;
  logic                     load;
  logic [TAPS*DW-1:0]       filter_coeff;
  logic [SIG_LEN*DW-1:0]    signal_in;
  logic [OUT_LEN*DW-1:0]    conv_result;
  logic                     is_completed;

  int total;
  int bad;

  convolve_engine #(
    .TAPS    (TAPS),
    .SIG_LEN (SIG_LEN),
    .DW      (DW),
    .FRAC    (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .filter_coeff (filter_coeff),
    .signal_in    (signal_in),
    .conv_result  (conv_result),
    .is_completed (is_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_load();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  // Counts rising edges from the first edge that samples load low.
  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    while (is_completed !== 1'b1 && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int nz;
    rst_n = 1'b0;
    filter_coeff = '1;
    signal_in    = '1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 load = ~load;
    end
    load = 1'b0;
    #1;
    total++;
    if (is_completed !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b exp=0", is_completed);
    end
    nz = 0;
    for (int n = 0; n < OUT_LEN; n++) if (conv_result[n*DW +: DW] !== 16'h0000) nz++;
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL reset_result nonzero_slots=%0d exp=0", nz);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_edges(10);
    total++;
    if (is_completed !== 1'b0) begin
      bad++;
      $display("FAIL idle_done got=%b exp=0", is_completed);
    end
    nz = 0;
    for (int n = 0; n < OUT_LEN; n++) if (conv_result[n*DW +: DW] !== 16'h0000) nz++;
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL idle_result nonzero_slots=%0d exp=0", nz);
    end
    $display("test_reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_impulse();
    int cyc;
    logic [DW-1:0] exp_v;
    filter_coeff = '0;
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = 16'(k * 256);
    signal_in = '0;
    signal_in[DW-1:0] = 16'h4000;
    pulse_load();
    wait_done(LAT + 50, cyc);
    total++;
    if (cyc !== LAT) begin
      bad++;
      $display("FAIL impulse_latency got=%0d exp=%0d", cyc, LAT);
    end
    for (int n = 0; n < OUT_LEN; n++) begin
      exp_v = (n < TAPS) ? 16'(n * 128) : 16'h0000;
      total++;
      if (conv_result[n*DW +: DW] !== exp_v) begin
        bad++;
        $display("FAIL impulse_y n=%0d got=%h exp=%h", n, conv_result[n*DW +: DW], exp_v);
      end
    end
    wait_edges(5);
    total++;
    if (is_completed !== 1'b1 || conv_result[5*DW +: DW] !== 16'h0280) begin
      bad++;
      $display("FAIL done_hold got=%b/%h exp=1/0280", is_completed, conv_result[5*DW +: DW]);
    end
    $display("test_impulse: latency=%0d total=%0d bad=%0d", cyc, total, bad);
  endtask

  task automatic test_passthrough();
    int cyc;
    logic [DW-1:0] exp_v;
    filter_coeff = '0;
    filter_coeff[DW-1:0] = 16'h7FFF;
    for (int n = 0; n < SIG_LEN; n++) signal_in[n*DW +: DW] = 16'h0100;
    pulse_load();
    signal_in = '1;
    filter_coeff = '1;
    wait_done(LAT + 50, cyc);
    total++;
    if (cyc !== LAT) begin
      bad++;
      $display("FAIL pass_latency got=%0d exp=%0d", cyc, LAT);
    end
    for (int n = 0; n < OUT_LEN; n++) begin
      exp_v = (n < SIG_LEN) ? 16'h00FF : 16'h0000;
      total++;
      if (conv_result[n*DW +: DW] !== exp_v) begin
        bad++;
        $display("FAIL pass_y n=%0d got=%h exp=%h", n, conv_result[n*DW +: DW], exp_v);
      end
    end
    $display("test_passthrough: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_saturation(input logic [DW-1:0] xval, input logic [DW-1:0] rail,
                                 input logic [DW-1:0] edge_v);
    int cyc;
    logic [DW-1:0] exp_v;
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = 16'h7FFF;
    for (int n = 0; n < SIG_LEN; n++) signal_in[n*DW +: DW] = xval;
    pulse_load();
    wait_done(LAT + 50, cyc);
    total++;
    if (cyc !== LAT) begin
      bad++;
      $display("FAIL sat_latency got=%0d exp=%0d", cyc, LAT);
    end
    for (int n = 0; n < OUT_LEN; n++) begin
      exp_v = (n == 0 || n == OUT_LEN - 1) ? edge_v : rail;
      total++;
      if (conv_result[n*DW +: DW] !== exp_v) begin
        bad++;
        $display("FAIL sat_y x=%h n=%0d got=%h exp=%h", xval, n, conv_result[n*DW +: DW], exp_v);
      end
    end
    $display("test_saturation x=%h: total=%0d bad=%0d", xval, total, bad);
  endtask

  task automatic test_restart();
    int cyc;
    int nz;
    logic [DW-1:0] exp_v;
    filter_coeff = '0;
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = 16'(k * 256);
    signal_in = '0;
    signal_in[DW-1:0] = 16'h4000;
    pulse_load();
    wait_edges(1000);
    total++;
    if (is_completed !== 1'b0) begin
      bad++;
      $display("FAIL restart_mid_done got=%b exp=0", is_completed);
    end
    filter_coeff = '0;
    filter_coeff[DW-1:0] = 16'h7FFF;
    for (int n = 0; n < SIG_LEN; n++) signal_in[n*DW +: DW] = 16'h0100;
    pulse_load();
    nz = 0;
    for (int n = 0; n < OUT_LEN; n++) if (conv_result[n*DW +: DW] !== 16'h0000) nz++;
    total++;
    if (nz !== 0 || is_completed !== 1'b0) begin
      bad++;
      $display("FAIL restart_clear nonzero_slots=%0d done=%b exp=0/0", nz, is_completed);
    end
    wait_done(LAT + 50, cyc);
    total++;
    if (cyc !== LAT) begin
      bad++;
      $display("FAIL restart_latency got=%0d exp=%0d", cyc, LAT);
    end
    for (int n = 0; n < OUT_LEN; n++) begin
      exp_v = (n < SIG_LEN) ? 16'h00FF : 16'h0000;
      total++;
      if (conv_result[n*DW +: DW] !== exp_v) begin
        bad++;
        $display("FAIL restart_y n=%0d got=%h exp=%h", n, conv_result[n*DW +: DW], exp_v);
      end
    end
    $display("test_restart: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_midrun_reset();
    int cyc;
    int nz;
    logic [DW-1:0] exp_v;
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = 16'h7FFF;
    for (int n = 0; n < SIG_LEN; n++) signal_in[n*DW +: DW] = 16'h7FFF;
    pulse_load();
    wait_edges(500);
    #3 rst_n = 1'b0;
    #1;
    nz = 0;
    for (int n = 0; n < OUT_LEN; n++) if (conv_result[n*DW +: DW] !== 16'h0000) nz++;
    total++;
    if (nz !== 0 || is_completed !== 1'b0) begin
      bad++;
      $display("FAIL async_reset nonzero_slots=%0d done=%b exp=0/0", nz, is_completed);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done(LAT + 200, cyc);
    total++;
    if (is_completed !== 1'b0) begin
      bad++;
      $display("FAIL no_done_after_reset got=%b exp=0 after=%0d", is_completed, cyc);
    end
    filter_coeff = '0;
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = 16'(k * 256);
    signal_in = '0;
    signal_in[DW-1:0] = 16'h4000;
    pulse_load();
    wait_done(LAT + 50, cyc);
    total++;
    if (cyc !== LAT) begin
      bad++;
      $display("FAIL fresh_latency got=%0d exp=%0d", cyc, LAT);
    end
    for (int n = 0; n < 40; n++) begin
      exp_v = (n < TAPS) ? 16'(n * 128) : 16'h0000;
      total++;
      if (conv_result[n*DW +: DW] !== exp_v) begin
        bad++;
        $display("FAIL fresh_y n=%0d got=%h exp=%h", n, conv_result[n*DW +: DW], exp_v);
      end
    end
    $display("test_midrun_reset: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    load  = 1'b0;
    rst_n = 1'b0;
    filter_coeff = '0;
    signal_in    = '0;
    test_reset();
    test_impulse();
    test_passthrough();
    test_saturation(16'h7FFF, 16'h7FFF, 16'h7FFE);
    test_saturation(16'h8000, 16'h8000, 16'h8001);
    test_restart();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
